// File: rtl/tick_gen_bank.sv
// tick_gen_bank: bank of independent programmable clock-enable generators.
// Each channel divides clk by (D+1), producing a one-cycle tick and a
// square wave that toggles on every terminal count. Divisor writes land in
// a shadow register and are applied only at a period boundary (terminal
// count), on restart, or immediately while the channel is stopped. A
// free-running prescaler provides power-of-two divided clocks.
module tick_gen_bank #(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = '0,
  parameter int                      PRE_W    = 17
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_CH-1:0]                            en,
  input  logic                                         restart,
  input  logic                                         cfg_we,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [CNT_W-1:0]                             cfg_div,
  output logic [NUM_CH-1:0]                            tick,
  output logic [NUM_CH-1:0]                            sq,
  output logic [NUM_CH-1:0]                            busy,
  output logic [PRE_W-1:0]                             pre_q
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PRE_W-1:0] pre_d;

  // Prescaler next value: plain wrap-around increment, independent of en/restart.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : ch_g
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] act_q, act_d;
      logic [CNT_W-1:0] shd_q, shd_d;
      logic             tick_q, tick_d;
      logic             sq_q, sq_d;
      logic             busy_q, busy_d;
      logic             wr;
      logic             tc;

      // Out-of-range channel numbers never match any channel index.
      assign wr = cfg_we && (cfg_ch == CH_W'(gi));
      assign tc = (cnt_q == act_q);

      // Channel next state: restart beats disable beats terminal count.
      always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        busy_d = busy_q;
        if (restart || !en[gi]) begin
          // Realign or stopped: counter parked, a coincident write is
          // applied straight through to the active divisor.
          cnt_d  = '0;
          shd_d  = wr ? cfg_div : shd_q;
          act_d  = wr ? cfg_div : shd_q;
          busy_d = 1'b0;
          if (restart) begin
            sq_d = 1'b0;
          end
        end else if (tc) begin
          // Period boundary: adopt the pending shadow (pre-write value);
          // a write in this same cycle stays pending for the next period.
          cnt_d  = '0;
          tick_d = 1'b1;
          sq_d   = ~sq_q;
          act_d  = shd_q;
          shd_d  = wr ? cfg_div : shd_q;
          busy_d = wr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (wr) begin
            shd_d  = cfg_div;
            busy_d = 1'b1;
          end
        end
      end

      // Channel registers; divisors come up at their build-time defaults.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q  <= '0;
          act_q  <= DIV_INIT[gi*CNT_W +: CNT_W];
          shd_q  <= DIV_INIT[gi*CNT_W +: CNT_W];
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
          busy_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          act_q  <= act_d;
          shd_q  <= shd_d;
          tick_q <= tick_d;
          sq_q   <= sq_d;
          busy_q <= busy_d;
        end
      end

      assign tick[gi] = tick_q;
      assign sq[gi]   = sq_q;
      assign busy[gi] = busy_q;
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_bank.sv
// Directed bench for tick_gen_bank: a 4-channel instance with divisors
// {ch0=9, ch1=0, ch2=1, ch3=3}, plus a 1-channel instance with a 5-bit
// prescaler so the wrap and the out-of-range channel write are reachable.
module tb_tick_gen_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        restart;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [3:0]  tick, sq, busy;
  logic [16:0] pre_q;

  logic        en_s;
  logic        restart_s;
  logic        cfg_we_s;
  logic [0:0]  cfg_ch_s;
  logic [7:0]  cfg_div_s;
  logic [0:0]  tick_s, sq_s, busy_s;
  logic [4:0]  pre_q_s;

  int n_checks = 0;
  int n_pass   = 0;

  int first_t  [4];
  int second_t [4];
  int cnt_t    [4];
  logic bpre_t [4];
  logic bat_t  [4];

  always #5 clk = ~clk;

  tick_gen_bank #(
    .NUM_CH  (4),
    .CNT_W   (32),
    .DIV_INIT({32'd3, 32'd1, 32'd0, 32'd9}),
    .PRE_W   (17)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .restart(restart),
    .cfg_we (cfg_we),
    .cfg_ch (cfg_ch),
    .cfg_div(cfg_div),
    .tick   (tick),
    .sq     (sq),
    .busy   (busy),
    .pre_q  (pre_q)
  );

  tick_gen_bank #(
    .NUM_CH  (1),
    .CNT_W   (8),
    .DIV_INIT(8'd2),
    .PRE_W   (5)
  ) u_dut_s (
    .clk    (clk),
    .rst    (rst),
    .en     (en_s),
    .restart(restart_s),
    .cfg_we (cfg_we_s),
    .cfg_ch (cfg_ch_s),
    .cfg_div(cfg_div_s),
    .tick   (tick_s),
    .sq     (sq_s),
    .busy   (busy_s),
    .pre_q  (pre_q_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observe n cycles (sampled on negedges); sample index 1 is the first one.
  task automatic scan(input int n);
    logic [3:0] prev;
    prev = busy;
    for (int ch = 0; ch < 4; ch++) begin
      first_t[ch]  = 0;
      second_t[ch] = 0;
      cnt_t[ch]    = 0;
      bpre_t[ch]   = 1'b0;
      bat_t[ch]    = 1'b0;
    end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if (tick[ch]) begin
          cnt_t[ch]++;
          if (first_t[ch] == 0) begin
            first_t[ch] = c;
            bpre_t[ch]  = prev[ch];
            bat_t[ch]   = busy[ch];
          end else if (second_t[ch] == 0) begin
            second_t[ch] = c;
          end
        end
      end
      prev = busy;
    end
  endtask

  initial begin
    int         ticks_s;
    logic [3:0] pre1_exp;
    rst       = 1'b1;
    en        = 4'h0;
    restart   = 1'b0;
    cfg_we    = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 32'd0;
    en_s      = 1'b1;
    restart_s = 1'b0;
    cfg_we_s  = 1'b0;
    cfg_ch_s  = 1'b0;
    cfg_div_s = 8'd0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_tick", {28'd0, tick}, 32'h0);
    check("rst_sq",   {28'd0, sq},   32'h0);
    check("rst_busy", {28'd0, busy}, 32'h0);
    check("rst_pre",  {15'd0, pre_q}, 32'h0);

    // Release and enable all channels (negedge N0).
    rst = 1'b0;
    en  = 4'hF;
    scan(44);
    check("ch0_first",  first_t[0],  10);
    check("ch0_second", second_t[0], 20);
    check("ch1_count",  cnt_t[1],    44);
    check("ch2_first",  first_t[2],  2);
    check("ch2_count",  cnt_t[2],    22);
    check("ch3_first",  first_t[3],  4);
    check("ch3_count",  cnt_t[3],    11);
    check("sq_at44",    {28'd0, sq}, 32'h8);
    check("pre_at44",   {15'd0, pre_q}, 44);

    // ch0 is 4 cycles into its period: reprogram to D=4.
    cfg_we  = 1'b1;
    cfg_ch  = 2'd0;
    cfg_div = 32'd4;
    @(negedge clk);
    cfg_we = 1'b0;
    check("busy_after_wr", {28'd0, busy}, 32'h1);
    scan(15);
    check("rp_first",  first_t[0], 5);
    check("rp_second", second_t[0], 10);
    check("rp_count",  cnt_t[0], 3);
    check("rp_bpre",   {31'd0, bpre_t[0]}, 1);
    check("rp_bat",    {31'd0, bat_t[0]}, 0);

    // Write ch3 D=2 so it is sampled in ch3's terminal-count cycle.
    repeat (3) @(negedge clk);
    cfg_we  = 1'b1;
    cfg_ch  = 2'd3;
    cfg_div = 32'd2;
    @(negedge clk);
    cfg_we = 1'b0;
    check("tc_tick3", {31'd0, tick[3]}, 1);
    check("tc_busy",  {28'd0, busy}, 32'h8);
    scan(12);
    check("tc_first",  first_t[3], 4);
    check("tc_second", second_t[3], 7);
    check("tc_bpre",   {31'd0, bpre_t[3]}, 1);
    check("tc_bat",    {31'd0, bat_t[3]}, 0);
    check("pre_at76",  {15'd0, pre_q}, 76);

    // Disable ch1 right after it toggles sq high, program D=7, re-enable.
    @(negedge clk);
    en = 4'b1101;
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_ch  = 2'd1;
    cfg_div = 32'd7;
    @(negedge clk);
    cfg_we = 1'b0;
    check("dis_busy",  {28'd0, busy}, 32'h0);
    check("dis_tick1", {31'd0, tick[1]}, 0);
    check("dis_sq1",   {31'd0, sq[1]}, 1);
    repeat (2) @(negedge clk);
    check("dis_sq1_hold", {31'd0, sq[1]}, 1);
    en = 4'hF;
    scan(10);
    check("en_first1", first_t[1], 8);
    check("en_count1", cnt_t[1], 1);
    check("en_sq1",    {31'd0, sq[1]}, 0);

    // Restart with channels at arbitrary phases.
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_tick", {28'd0, tick}, 32'h0);
    check("rs_sq",   {28'd0, sq},   32'h0);
    check("rs_pre",  {15'd0, pre_q}, 92);
    scan(10);
    check("rs_first0", first_t[0], 5);
    check("rs_first1", first_t[1], 8);
    check("rs_first2", first_t[2], 2);
    check("rs_first3", first_t[3], 3);
    check("rs_pre2",   {15'd0, pre_q}, 102);

    // Asynchronous reset between clock edges.
    #3 rst = 1'b1;
    #1;
    check("ar_tick",  {28'd0, tick}, 32'h0);
    check("ar_sq",    {28'd0, sq},   32'h0);
    check("ar_busy",  {28'd0, busy}, 32'h0);
    check("ar_pre",   {15'd0, pre_q}, 32'h0);
    check("ar_pre_s", {27'd0, pre_q_s}, 32'h0);

    // Release; out-of-range write on the 1-channel instance.
    @(negedge clk);
    rst       = 1'b0;
    cfg_we_s  = 1'b1;
    cfg_ch_s  = 1'b1;
    cfg_div_s = 8'd5;
    ticks_s   = 0;
    pre1_exp  = 4'b0110;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (tick_s[0]) ticks_s++;
      if (k == 1) begin
        cfg_we_s = 1'b0;
        check("oor_busy", {31'd0, busy_s}, 0);
      end
      if (k <= 4) check("pre_bit1", {31'd0, pre_q[1]}, {31'd0, pre1_exp[k-1]});
      if (k == 10) check("ar_tick10", {28'd0, tick}, 32'h7);
      if (k == 31) check("wrap_top",  {27'd0, pre_q_s}, 32'h1F);
      if (k == 32) check("wrap_zero", {27'd0, pre_q_s}, 32'h0);
    end
    check("oor_ticks", ticks_s, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
